// File: rtl/hazard_ctrl_param.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use
// stalls lasting MEM_LAT cycles, taken-branch flushes and saturating counters.
module hazard_ctrl_param #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  regwrite_ex,
  input  logic                  regwrite_mem,
  input  logic                  regwrite_wb,
  input  logic                  memread_ex,
  input  logic                  branch_taken_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  busy_stall,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu;
  logic             flush_evt;

  // MEM beats WB so the youngest producer wins; x0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs))
      return 2'b10;
    else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = RESET_N ? fwd_sel(rs1_ex) : 2'b00;
    fwd_b = RESET_N ? fwd_sel(rs2_ex) : 2'b00;
  end

  assign lu = memread_ex && regwrite_ex && (rd_ex != '0) &&
              ((use_rs1_id && (rd_ex == rs1_id)) || (use_rs2_id && (rd_ex == rs2_id)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    busy_stall  = 1'b0;
    flush_evt   = 1'b0;
    if (!RESET_N) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_ex) begin
            // A load squashed by the branch never gets to stall.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_evt   = 1'b1;
          end else if (lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (MEM_LAT > 1) begin
              state_d = LSTALL;
              cnt_d   = LAT_W'(MEM_LAT - 1);
            end
          end
        end
        LSTALL: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          busy_stall  = 1'b1;
          cnt_d       = cnt_q - LAT_W'(1);
          if (cnt_q <= LAT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_pc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Hazard-resolution controller for the next-generation 5-stage pipelined core. It succeeds the hazard-free pipeline, whose programs need hand-inserted NOPs.
- Produces EX-stage forwarding selects, load-use stalls of parametrised memory latency, and branch flushes.
- Keeps saturating stall/flush performance counters.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enable/clear inputs.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_LAT, 1, data-memory read latency in cycles; load-use stall length (must be >= 1)
CNT_W, 32, width of performance counters

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  synchronous active-low reset
rs1_id, rs2_id  in  REG_ADDR_W  source registers of instruction in ID
use_rs1_id, use_rs2_id  in  1  ID instruction actually reads rs1/rs2
rs1_ex, rs2_ex  in  REG_ADDR_W  source registers of instruction in EX
rd_ex, rd_mem, rd_wb  in  REG_ADDR_W  destination registers in EX/MEM/WB
regwrite_ex, regwrite_mem, regwrite_wb  in  1  stage writes rd
memread_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  taken branch/jump resolved in EX
fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 01 WB, 10 MEM
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
flush_if_id  out  1  clear IF/ID to NOP
flush_id_ex  out  1  clear ID/EX to bubble
busy_stall  out  1  FSM in LSTALL
stall_cnt  out  CNT_W  cycles with stall_pc high
flush_cnt  out  CNT_W  branch flush events

Behaviour:
Forwarding (combinational, independent of FSM):
- fwd_a = 10 if regwrite_mem and rd_mem!=0 and rd_mem==rs1_ex.
- Else fwd_a = 01 if regwrite_wb and rd_wb!=0 and rd_wb==rs1_ex.
- Else fwd_a = 00.
- fwd_b is identical with rs2_ex.
- MEM has priority over WB. x0 is never forwarded.

Load-use detect (lu):
- lu = memread_ex and regwrite_ex and rd_ex!=0 and ((use_rs1_id and rd_ex==rs1_id) or (use_rs2_id and rd_ex==rs2_id)).

FSM states RUN, LSTALL; internal down-counter cnt of width ceil(log2(MEM_LAT+1)).
- RUN, branch_taken_ex=1:
  - flush_if_id=1, flush_id_ex=1, stall_*=0.
  - Branch has priority over lu in the same cycle; the load being squashed is not a stall.
  - flush_cnt increments. Stay in RUN.
- RUN, lu=1, no branch:
  - stall_pc=1, stall_if_id=1, flush_id_ex=1 (bubble), flush_if_id=0.
  - If MEM_LAT==1, stay in RUN.
  - Else go to LSTALL with cnt=MEM_LAT-1.
- RUN, otherwise: all control outputs 0.
- LSTALL:
  - stall_pc=1, stall_if_id=1, flush_id_ex=1, busy_stall=1.
  - branch_taken_ex is ignored (EX holds a bubble).
  - cnt decrements each cycle; when cnt==1, next state is RUN.
- Total stall for one load-use = exactly MEM_LAT cycles. The ID instruction enters EX the cycle after the last stall cycle.
- busy_stall=1 only in LSTALL.

Counters:
- stall_cnt increments on every cycle with stall_pc=1; flush_cnt on every cycle with a branch flush.
- Both saturate at 2^CNT_W-1 (no wrap).
- Counters are registered and update on the edge after the event.

Reset (RESET_N=0 sampled at rising edge):
- state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
- While RESET_N=0: flush_if_id=1, flush_id_ex=1, stall_pc=0, stall_if_id=0, busy_stall=0, fwd_*=00, counters do not increment.
- Reset asserted mid-LSTALL aborts the stall; the next cycle after release is RUN.

Test Plan:
- Reset: hold RESET_N=0 for 3 cycles, then release -> flush_if_id=flush_id_ex=1 during reset; after release all controls 0, stall_cnt=flush_cnt=0.
- Forwarding priority: rs1_ex=5, rd_mem=5, rd_wb=5, both regwrite=1 -> fwd_a=10. With regwrite_mem=0 -> 01. With rd_mem=rd_wb=0 -> 00.
- Load-use, MEM_LAT=1: memread_ex=1, rd_ex=3, rs2_id=3, use_rs2_id=1 -> stall_pc/stall_if_id/flush_id_ex high for 1 cycle; stall_cnt=1. Repeat with use_rs2_id=0 -> no stall.
- Load-use, MEM_LAT=3: same stimulus -> stall high exactly 3 cycles, busy_stall high for cycles 2-3. Asserting branch_taken_ex during cycle 2 gives no flush_if_id; stall_cnt=3.
- Branch vs load-use in same cycle: branch_taken_ex=1 with lu=1 -> flush_if_id=flush_id_ex=1, stall_pc=0, flush_cnt=1, stall_cnt unchanged.
- Reset mid-LSTALL (MEM_LAT=4): assert RESET_N=0 in cycle 2 -> busy_stall=0 next cycle, counters 0. Bench also forces stall_cnt near max (CNT_W=4, 20 stall cycles) -> stall_cnt=15 and holds.
